// File: rtl/flow_monitor_if.sv
// Observation bundle for flow_monitor: the processor's fetch stream and regfile write port.
// The processor side drives through master; the monitor listens through slave.
interface flow_monitor_if #(
    parameter int PC_W = 12
);
    logic            fetch_valid;
    logic [PC_W-1:0] fetch_pc;
    logic [31:0]     fetch_instr;
    logic [31:0]     rs_a_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, rs_a_data,
        output rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input fetch_valid, fetch_pc, fetch_instr, rs_a_data,
        input rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/flow_monitor.sv
// Control-flow and link-writeback monitor: checks each PC transition and every jal/setx link write.
// Build option FLOW_MONITOR_HALT_ON_ERR_EN: freeze the monitor in S_HALT on the first error.
module flow_monitor #(
    parameter int PC_W       = 12,
    parameter int PEND_DEPTH = 4,
    parameter int END_PC     = 24,
    parameter int MAX_CYCLES = 2000,
    parameter int LAT_MAX    = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    flow_monitor_if.slave   mon,
    output logic            chk_pass,
    output logic            err_flag,
    output logic [3:0]      err_code,
    output logic [PC_W-1:0] err_pc,
    output logic [7:0]      err_count,
    output logic [15:0]     insn_count,
    output logic            done,
    output logic            timeout
);
    localparam int AW    = $clog2(PEND_DEPTH);
    localparam int CW    = AW + 1;
    localparam int AGE_W = $clog2(LAT_MAX + 2);

    localparam logic [CW-1:0]    Q_FULL   = CW'(PEND_DEPTH);
    localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(LAT_MAX);
    localparam logic [PC_W-1:0]  END_PC_V = PC_W'(END_PC);
    localparam logic [15:0]      MAX_V    = 16'(MAX_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]       state, state_nxt;
    logic             have_prev;

    // Previous-fetch stage: the instruction whose successor is checked next
    logic [PC_W-1:0]  pc_p1;
    logic [31:0]      instr_p1;
    logic [31:0]      a_data_p1;

    logic [4:0]       q_reg [PEND_DEPTH];
    logic [31:0]      q_val [PEND_DEPTH];
    logic [PC_W-1:0]  q_pc  [PEND_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    q_cnt;
    logic [AGE_W-1:0] age;

    logic             frozen, active, fetch_act, do_check;
    logic [4:0]       op;
    logic [PC_W-1:0]  tgt, nxt, br;
    logic             pc_err;
    logic [3:0]       pc_code;
    logic             push_req, push, pop, q_empty, head_hit, aged, overflow;
    logic [4:0]       push_reg;
    logic [31:0]      push_val;
    logic [15:0]      cnt_next;
    logic             end_hit, tmo_hit;
    logic [9:1]       errs;
    logic             any_err;
    logic [3:0]       first_code;
    logic [PC_W-1:0]  first_pc;

    assign frozen    = (state == S_DONE) || (state == S_HALT);
    assign active    = !frozen;
    assign fetch_act = active && mon.fetch_valid;
    assign do_check  = fetch_act && have_prev;

    assign op  = instr_p1[31:27];
    assign tgt = PC_W'(instr_p1[26:0]);
    assign nxt = pc_p1 + 1'b1;
    assign br  = nxt + PC_W'($signed(instr_p1[16:0]));

    always_comb begin
        pc_code = 4'd0;
        case (op)
            OP_J, OP_JAL:   if (mon.fetch_pc != tgt) pc_code = 4'd2;
            OP_JR:          if (mon.fetch_pc != a_data_p1[PC_W-1:0]) pc_code = 4'd3;
            OP_BNE, OP_BLT: if (mon.fetch_pc != nxt && mon.fetch_pc != br) pc_code = 4'd4;
            OP_BEX:         if (mon.fetch_pc != ((a_data_p1 != 32'd0) ? tgt : nxt)) pc_code = 4'd5;
            default:        if (mon.fetch_pc != nxt) pc_code = 4'd1;
        endcase
    end
    assign pc_err = do_check && (pc_code != 4'd0);

    // Link value for jal is a full 32-bit add, so PC_W wrap does not apply
    assign push_req = do_check && (op == OP_JAL || op == OP_SETX);
    assign push_reg = (op == OP_JAL) ? 5'd31 : 5'd30;
    assign push_val = (op == OP_JAL) ? (32'(pc_p1) + 32'd1) : {5'd0, instr_p1[26:0]};

    // Writes only see entries already queued, so a same-cycle push to empty never matches
    assign q_empty  = (q_cnt == '0);
    assign head_hit = active && !q_empty && mon.rf_we && (mon.rf_waddr != 5'd0)
                      && (mon.rf_waddr == q_reg[rd_ptr]);
    assign aged     = active && !q_empty && !head_hit && (age > AGE_LIM);
    assign pop      = head_hit || aged;
    assign overflow = push_req && (q_cnt == Q_FULL) && !pop;
    assign push     = push_req && !overflow;

    assign cnt_next = sat_inc16(insn_count);
    assign end_hit  = fetch_act && (mon.fetch_pc == END_PC_V);
    assign tmo_hit  = fetch_act && !end_hit && (cnt_next == MAX_V);

    always_comb begin
        errs       = '0;
        errs[1]    = pc_err && (pc_code == 4'd1);
        errs[2]    = pc_err && (pc_code == 4'd2);
        errs[3]    = pc_err && (pc_code == 4'd3);
        errs[4]    = pc_err && (pc_code == 4'd4);
        errs[5]    = pc_err && (pc_code == 4'd5);
        errs[6]    = head_hit && (mon.rf_wdata != q_val[rd_ptr]);
        errs[7]    = overflow;
        errs[8]    = aged;
        errs[9]    = tmo_hit;
        first_code = 4'd0;
        for (int c = 9; c >= 1; c--) begin
            if (errs[c]) first_code = 4'(c);
        end
    end
    assign any_err  = |errs;
    assign first_pc = (first_code == 4'd6 || first_code == 4'd8) ? q_pc[rd_ptr] : pc_p1;

    always_comb begin
        state_nxt = state;
        if (fetch_act) begin
            if (end_hit || tmo_hit) state_nxt = S_DONE;
            else                    state_nxt = S_RUN;
        end
`ifdef FLOW_MONITOR_HALT_ON_ERR_EN
        if (active && any_err) state_nxt = S_HALT;
`endif
    end

    // Check-result stage: status registered one cycle after the checking fetch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            have_prev  <= 1'b0;
            chk_pass   <= 1'b0;
            err_flag   <= 1'b0;
            err_code   <= 4'd0;
            err_pc     <= '0;
            err_count  <= 8'd0;
            insn_count <= 16'd0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q_cnt      <= '0;
            age        <= '0;
        end else begin
            state    <= state_nxt;
            chk_pass <= do_check && !pc_err;
            if (fetch_act) begin
                have_prev  <= 1'b1;
                insn_count <= cnt_next;
            end
            if (any_err) begin
                err_count <= sat_inc8(err_count);
                if (!err_flag) begin
                    err_flag <= 1'b1;
                    err_code <= first_code;
                    err_pc   <= first_pc;
                end
            end
            if (end_hit) done    <= 1'b1;
            if (tmo_hit) timeout <= 1'b1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      q_cnt <= q_cnt + 1'b1;
            else if (pop && !push) q_cnt <= q_cnt - 1'b1;

            if (pop || (push && q_empty))             age <= '0;
            else if (active && !q_empty && age <= AGE_LIM) age <= age + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fetch_act) begin
            pc_p1     <= mon.fetch_pc;
            instr_p1  <= mon.fetch_instr;
            a_data_p1 <= mon.rs_a_data;
        end
        if (push) begin
            q_reg[wr_ptr] <= push_reg;
            q_val[wr_ptr] <= push_val;
            q_pc[wr_ptr]  <= pc_p1;
        end
    end
endmodule

// File: tb/tb_flow_monitor.sv
// Self-checking bench for flow_monitor: chk_pass expectations go through a scoreboard queue,
// error/status fields are compared inline in each scenario task.
module tb_flow_monitor;
    localparam int PC_W    = 12;
    localparam int LAT_MAX = 8;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    logic            clock;
    logic            reset_n;
    logic            chk_pass, err_flag, done, timeout;
    logic [3:0]      err_code;
    logic [PC_W-1:0] err_pc;
    logic [7:0]      err_count;
    logic [15:0]     insn_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    flow_monitor_if #(.PC_W(PC_W)) mon_if ();

    flow_monitor #(
        .PC_W(PC_W), .PEND_DEPTH(4), .END_PC(24), .MAX_CYCLES(2000), .LAT_MAX(LAT_MAX)
    ) dut (
        .clock(clock), .reset_n(reset_n), .mon(mon_if),
        .chk_pass(chk_pass), .err_flag(err_flag), .err_code(err_code), .err_pc(err_pc),
        .err_count(err_count), .insn_count(insn_count), .done(done), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input int t);
        logic [31:0] v;
        v = t;
        return {op, v[26:0]};
    endfunction

    // All tasks start and end on a falling edge; outputs are sampled there.
    task automatic fetch_w(input int pc, input logic [31:0] instr, input logic [31:0] a,
                           input bit exp, input bit we, input logic [4:0] wr, input logic [31:0] wd);
        bit e;
        mon_if.fetch_valid = 1'b1;
        mon_if.fetch_pc    = PC_W'(pc);
        mon_if.fetch_instr = instr;
        mon_if.rs_a_data   = a;
        mon_if.rf_we       = we;
        mon_if.rf_waddr    = wr;
        mon_if.rf_wdata    = wd;
        exp_q.push_back(exp);
        @(negedge clock);
        mon_if.fetch_valid = 1'b0;
        mon_if.rf_we       = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (chk_pass !== e) begin
            n_fail++;
            $display("FAIL chk_pass pc=%0d: got %b want %b", pc, chk_pass, e);
        end
    endtask

    task automatic fetch(input int pc, input logic [31:0] instr, input logic [31:0] a, input bit exp);
        fetch_w(pc, instr, a, exp, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic rf_write(input logic [4:0] wr, input logic [31:0] wd);
        mon_if.rf_we    = 1'b1;
        mon_if.rf_waddr = wr;
        mon_if.rf_wdata = wd;
        @(negedge clock);
        mon_if.rf_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        mon_if.fetch_valid = 1'b0;
        mon_if.fetch_pc    = '0;
        mon_if.fetch_instr = '0;
        mon_if.rs_a_data   = '0;
        mon_if.rf_we       = 1'b0;
        mon_if.rf_waddr    = '0;
        mon_if.rf_wdata    = '0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({chk_pass, err_flag, err_code, err_pc, err_count, insn_count, done, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flag=%b code=%0d cnt=%0d insn=%0d done=%b to=%b want all 0",
                     err_flag, err_code, err_count, insn_count, done, timeout);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        fetch(0, mk(OP_ADD, 0), 0, 1'b0);
        for (int i = 1; i < 4; i++) fetch(i, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL seq_err_flag: got %b want 0", err_flag); end
        n_tests++;
        if (insn_count !== 16'd4) begin n_fail++; $display("FAIL seq_insn_count: got %0d want 4", insn_count); end
    endtask

    task automatic test_jal();
        apply_reset();
        fetch(5, mk(OP_JAL, 10), 0, 1'b0);
        fetch(10, mk(OP_ADD, 0), 0, 1'b1);
        rf_write(5'd30, 32'd6);
        rf_write(5'd0, 32'd6);
        rf_write(5'd31, 32'd6);
        idle(LAT_MAX + 4);
        n_tests++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL jal_match: got err_flag %b code %0d want 0", err_flag, err_code); end

        apply_reset();
        fetch(5, mk(OP_JAL, 10), 0, 1'b0);
        fetch(10, mk(OP_ADD, 0), 0, 1'b1);
        rf_write(5'd31, 32'd7);
        n_tests++;
        if (err_code !== 4'd6) begin n_fail++; $display("FAIL jal_wdata_code: got %0d want 6", err_code); end
        n_tests++;
        if (err_pc !== 12'd5) begin n_fail++; $display("FAIL jal_wdata_pc: got %0d want 5", err_pc); end

        // A write in the same cycle as the push to an empty queue must not retire it.
        apply_reset();
        fetch(5, mk(OP_JAL, 10), 0, 1'b0);
        fetch_w(10, mk(OP_ADD, 0), 0, 1'b1, 1'b1, 5'd31, 32'd6);
        idle(LAT_MAX + 3);
        n_tests++;
        if (err_code !== 4'd8) begin n_fail++; $display("FAIL write_before_push: got code %0d want 8", err_code); end
    endtask

    task automatic test_branch();
        apply_reset();
        fetch(8, mk(OP_BNE, -3), 0, 1'b0);
        fetch(6, mk(OP_J, 8), 0, 1'b1);
        fetch(8, mk(OP_BNE, -3), 0, 1'b1);
        fetch(9, mk(OP_J, 8), 0, 1'b1);
        fetch(8, mk(OP_BNE, -3), 0, 1'b1);
        fetch(7, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (err_code !== 4'd4) begin n_fail++; $display("FAIL bne_code: got %0d want 4", err_code); end
        n_tests++;
        if (err_pc !== 12'd8) begin n_fail++; $display("FAIL bne_pc: got %0d want 8", err_pc); end
    endtask

    task automatic test_bex_jr();
        apply_reset();
        fetch(0, mk(OP_BEX, 20), 1, 1'b0);
        fetch(20, mk(OP_ADD, 0), 0, 1'b1);
        fetch(21, mk(OP_BEX, 20), 0, 1'b1);
        fetch(20, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (err_code !== 4'd5 || err_pc !== 12'd21) begin
            n_fail++; $display("FAIL bex_err: got code %0d pc %0d want 5 / 21", err_code, err_pc);
        end

        apply_reset();
        fetch(3, mk(OP_JR, 0), 40, 1'b0);
        fetch(40, mk(OP_ADD, 0), 0, 1'b1);
        fetch(41, mk(OP_JR, 0), 50, 1'b1);
        fetch(52, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (err_code !== 4'd3 || err_pc !== 12'd41) begin
            n_fail++; $display("FAIL jr_err: got code %0d pc %0d want 3 / 41", err_code, err_pc);
        end
    endtask

    task automatic test_first_error();
        apply_reset();
        fetch(0, mk(OP_ADD, 0), 0, 1'b0);
        fetch(2, mk(OP_J, 30), 0, 1'b0);
        fetch(31, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (err_code !== 4'd1 || err_pc !== 12'd0) begin
            n_fail++; $display("FAIL first_err_hold: got code %0d pc %0d want 1 / 0", err_code, err_pc);
        end
        n_tests++;
`ifdef FLOW_MONITOR_HALT_ON_ERR_EN
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_count: got %0d want 1", err_count); end
`else
        if (err_count !== 8'd2) begin n_fail++; $display("FAIL err_count: got %0d want 2", err_count); end
`endif
    endtask

    task automatic test_fifo();
        apply_reset();
        fetch(0, mk(OP_SETX, 100), 0, 1'b0);
        for (int i = 1; i < 5; i++) fetch(i, mk(OP_SETX, 100 + i), 0, 1'b1);
        fetch(5, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (err_code !== 4'd7 || err_pc !== 12'd4) begin
            n_fail++; $display("FAIL overflow: got code %0d pc %0d want 7 / 4", err_code, err_pc);
        end
        rf_write(5'd30, 32'd100);
        rf_write(5'd30, 32'd101);
        n_tests++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL fifo_order: got err_count %0d want 1", err_count); end

        apply_reset();
        fetch(0, mk(OP_SETX, 5), 0, 1'b0);
        fetch(1, mk(OP_ADD, 0), 0, 1'b1);
        idle(LAT_MAX);
        n_tests++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL age_early: got err_flag %b want 0", err_flag); end
        idle(2);
        n_tests++;
        if (err_code !== 4'd8 || err_pc !== 12'd0) begin
            n_fail++; $display("FAIL age_limit: got code %0d pc %0d want 8 / 0", err_code, err_pc);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fetch(5, mk(OP_JAL, 10), 0, 1'b0);
        fetch(10, mk(OP_SETX, 77), 0, 1'b1);
        fetch_w(11, mk(OP_ADD, 0), 0, 1'b1, 1'b1, 5'd31, 32'd6);
        rf_write(5'd30, 32'd77);
        idle(LAT_MAX + 4);
        n_tests++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL push_pop_same_cycle: got err_flag %b code %0d want 0", err_flag, err_code); end
    endtask

    task automatic test_done();
        apply_reset();
        fetch(20, mk(OP_ADD, 0), 0, 1'b0);
        for (int i = 21; i <= 24; i++) fetch(i, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_set: got %b want 1", done); end
        fetch(26, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (err_flag !== 1'b0 || insn_count !== 16'd5) begin
            n_fail++; $display("FAIL done_absorb: got err_flag %b insn %0d want 0 / 5", err_flag, insn_count);
        end
        // Reset mid-run clears outputs without waiting for a clock edge.
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (done !== 1'b0 || insn_count !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: got done %b insn %0d want 0 / 0", done, insn_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        fetch(7, mk(OP_ADD, 0), 0, 1'b0);
        fetch(8, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL restart_first_fetch: got err_flag %b want 0", err_flag); end
    endtask

    task automatic test_timeout();
        apply_reset();
        fetch(100, mk(OP_ADD, 0), 0, 1'b0);
        for (int i = 1; i < 1999; i++) fetch(100 + i, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (timeout !== 1'b0 || insn_count !== 16'd1999) begin
            n_fail++; $display("FAIL timeout_early: got to %b insn %0d want 0 / 1999", timeout, insn_count);
        end
        fetch(2099, mk(OP_ADD, 0), 0, 1'b1);
        n_tests++;
        if (timeout !== 1'b1 || err_code !== 4'd9 || done !== 1'b0) begin
            n_fail++; $display("FAIL timeout_set: got to %b code %0d done %b want 1 / 9 / 0", timeout, err_code, done);
        end
        fetch(2100, mk(OP_ADD, 0), 0, 1'b0);
        n_tests++;
        if (insn_count !== 16'd2000) begin n_fail++; $display("FAIL timeout_freeze: got insn %0d want 2000", insn_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_bex_jr();
        test_first_error();
        test_fifo();
        test_back_to_back();
        test_done();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
